// File: rtl/sample_averager_if.sv
// Handshake bundle for sample_averager: dav_/rfd sample input and dav_/rfd mean output.
// slave = averager side, master = producer/consumer (bench) side.
interface sample_averager_if;
  logic       in_dav_;
  logic [7:0] in_data;
  logic       in_rfd;
  logic       out_dav_;
  logic [7:0] out_data;
  logic       out_rfd;

  modport slave  (input  in_dav_, in_data, out_rfd,
                  output in_rfd, out_dav_, out_data);
  modport master (output in_dav_, in_data, out_rfd,
                  input  in_rfd, out_dav_, out_data);
endinterface

// File: rtl/sample_averager.sv
// Block averager: accumulates 2^LOG2N signed samples over a four-phase handshake and emits the mean.
// Define AVG_ROUND_EN to round half toward +inf instead of flooring.
module sample_averager #(
  parameter int LOG2N = 2
) (
  input  logic              clock,
  input  logic              reset_,
  sample_averager_if.slave  bus
);
  localparam int N  = 1 << LOG2N;
  localparam int AW = 8 + LOG2N;
  localparam int CW = LOG2N + 1;

  typedef enum logic [2:0] {S0, S1, S2, S3, S4} state_t;

  state_t                state_q, state_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  in_rfd_q, in_rfd_d;
  logic                  out_dav_q, out_dav_d;
  logic [7:0]            out_data_q, out_data_d;

  logic signed [AW-1:0]  sample_ext;
  logic [7:0]            mean;

  assign sample_ext = AW'(signed'(bus.in_data));

`ifdef AVG_ROUND_EN
  // One guard bit keeps acc + N/2 from wrapping at the positive extreme.
  logic signed [AW:0]    acc_rnd;
  assign acc_rnd = (AW+1)'(acc_q) + (AW+1)'(N / 2);
  assign mean    = 8'(acc_rnd >>> LOG2N);
`else
  assign mean    = 8'(acc_q >>> LOG2N);
`endif

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q    <= S0;
      acc_q      <= '0;
      cnt_q      <= '0;
      in_rfd_q   <= 1'b1;
      out_dav_q  <= 1'b1;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      in_rfd_q   <= in_rfd_d;
      out_dav_q  <= out_dav_d;
      out_data_q <= out_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    in_rfd_d   = in_rfd_q;
    out_dav_d  = out_dav_q;
    out_data_d = out_data_q;
    case (state_q)
      S0: if (!bus.in_dav_) begin
        acc_d    = acc_q + sample_ext;
        cnt_d    = cnt_q + CW'(1);
        in_rfd_d = 1'b0;
        state_d  = S1;
      end
      // A full block keeps in_rfd low so the producer stalls until the result is taken.
      S1: if (bus.in_dav_) begin
        if (cnt_q == CW'(N)) begin
          state_d = S2;
        end else begin
          in_rfd_d = 1'b1;
          state_d  = S0;
        end
      end
      S2: begin
        out_data_d = mean;
        out_dav_d  = 1'b0;
        state_d    = S3;
      end
      S3: if (!bus.out_rfd) begin
        out_dav_d = 1'b1;
        state_d   = S4;
      end
      S4: if (bus.out_rfd) begin
        acc_d    = '0;
        cnt_d    = '0;
        in_rfd_d = 1'b1;
        state_d  = S0;
      end
      default: state_d = S0;
    endcase
  end

  assign bus.in_rfd   = in_rfd_q;
  assign bus.out_dav_ = out_dav_q;
  assign bus.out_data = out_data_q;
endmodule

// File: tb/tb_sample_averager.sv
// Scoreboard bench for sample_averager (LOG2N=2): producer pushes expected means, consumer monitor pops and checks.
module tb_sample_averager;
  logic clock = 1'b0;
  logic reset_ = 1'b0;
  always #5 clock = ~clock;

  sample_averager_if bus ();
  sample_averager #(.LOG2N(2)) dut (.clock(clock), .reset_(reset_), .bus(bus));

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  int         bp_cycles = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_rfd(logic v, int limit, string name);
    int k = 0;
    while (bus.in_rfd !== v && k < limit) begin
      @(posedge clock); #1;
      k++;
    end
    if (bus.in_rfd !== v) check(name, bus.in_rfd, v);
  endtask

  // eager: assert dav_ without first seeing rfd high, to probe that stalled input is not taken.
  task automatic send(logic [7:0] d, bit eager = 1'b0);
    if (!eager) wait_rfd(1'b1, 200, "rfd_high_timeout");
    bus.in_data = d;
    bus.in_dav_ = 1'b0;
    if (eager) wait_rfd(1'b1, 200, "rfd_release_timeout");
    wait_rfd(1'b0, 200, "rfd_low_timeout");
    bus.in_dav_ = 1'b1;
  endtask

  task automatic block(logic [7:0] a, logic [7:0] b, logic [7:0] c, logic [7:0] d,
                       logic [7:0] e_floor, logic [7:0] e_round);
`ifdef AVG_ROUND_EN
    exp_q.push_back(e_round);
`else
    exp_q.push_back(e_floor);
`endif
    send(a); send(b); send(c); send(d);
  endtask

  // Consumer / monitor
  initial begin
    bus.out_rfd = 1'b1;
    forever begin
      @(negedge clock);
      if (reset_ && bus.out_dav_ === 1'b0) begin
        logic [7:0] e;
        logic [7:0] held;
        int k;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got 0x%0h, expected no result", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          check("mean", bus.out_data, e);
        end
        held = bus.out_data;
        for (int i = 0; i < bp_cycles; i++) begin
          @(negedge clock);
          check("bp_out_dav_low", bus.out_dav_, 1'b0);
          check("bp_out_data_stable", bus.out_data, held);
          check("bp_in_rfd_low", bus.in_rfd, 1'b0);
        end
        bp_cycles = 0;
        bus.out_rfd = 1'b0;
        k = 0;
        while (bus.out_dav_ !== 1'b1 && k < 50) begin
          @(negedge clock);
          k++;
        end
        if (bus.out_dav_ !== 1'b1) check("out_dav_release_timeout", bus.out_dav_, 1'b1);
        check("out_data_hold_after_ack", bus.out_data, held);
        bus.out_rfd = 1'b1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    bus.in_dav_ = 1'b1;
    bus.in_data = 8'h00;
    repeat (3) @(posedge clock);
    #3 reset_ = 1'b1;
    @(negedge clock);
    check("rst_in_rfd", bus.in_rfd, 1'b1);
    check("rst_out_dav", bus.out_dav_, 1'b1);
    check("rst_out_data", bus.out_data, 8'h00);
    repeat (10) @(posedge clock);
    #1;
    check("idle_in_rfd", bus.in_rfd, 1'b1);
    check("idle_out_dav", bus.out_dav_, 1'b1);
    check("idle_out_data", bus.out_data, 8'h00);

    block(8'd10, 8'd20, 8'd30, 8'd40, 8'h19, 8'h19);
    block(8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'hFD, 8'hFE);
    block(8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F);
    block(8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80);
    block(8'h7F, 8'h80, 8'h7F, 8'h80, 8'hFF, 8'h00);

    // Backpressure: consumer holds 20 cycles; producer tries a 5th sample early.
    bp_cycles = 20;
    block(8'd1, 8'd2, 8'd3, 8'd6, 8'h03, 8'h03);
    exp_q.push_back(8'h08);
    repeat (3) @(posedge clock);
    #1;
    send(8'd8, 1'b1);
    send(8'd8); send(8'd8); send(8'd8);

    // Asynchronous reset in the middle of a block discards the partial sum.
    send(8'd100); send(8'd100);
    wait_rfd(1'b1, 200, "rfd_high_timeout");
    bus.in_data = 8'd100;
    bus.in_dav_ = 1'b0;
    wait_rfd(1'b0, 200, "rfd_low_timeout");
    #2 reset_ = 1'b0;
    #1;
    check("midrst_in_rfd", bus.in_rfd, 1'b1);
    check("midrst_out_dav", bus.out_dav_, 1'b1);
    check("midrst_out_data", bus.out_data, 8'h00);
    bus.in_dav_ = 1'b1;
    @(posedge clock);
    #3 reset_ = 1'b1;
    block(8'd4, 8'd4, 8'd4, 8'd4, 8'h04, 8'h04);

    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clock);
      k++;
    end
    repeat (5) @(posedge clock);
    check("queue_drained", exp_q.size(), 0);
    #1;
    check("final_in_rfd", bus.in_rfd, 1'b1);
    check("final_out_data", bus.out_data, 8'h04);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
